// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier controller: state
// encoding, step identifiers and the per-step shift table.
package mult_seq_ctrl_pkg;

    // Controller states. Encoding 2'd3 is unused and behaves as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Partial-product steps, in issue order.
    // Bit 0 of the step selects the high half of operand a.
    // Bit 1 of the step selects the high half of operand b.
    localparam logic [1:0] STEP_LL = 2'd0;  // a_lo * b_lo
    localparam logic [1:0] STEP_HL = 2'd1;  // a_hi * b_lo
    localparam logic [1:0] STEP_LH = 2'd2;  // a_lo * b_hi
    localparam logic [1:0] STEP_HH = 2'd3;  // a_hi * b_hi

    localparam int unsigned NUM_STEPS = 4;

    // Left shift applied to a step's partial product before accumulation:
    // 0, HALF, HALF, WIDTH (= 2*HALF).
    function automatic int unsigned step_shift(input logic [1:0] step,
                                               input int unsigned half);
        int unsigned sh;
        sh = 0;
        case (step)
            STEP_LL: sh = 0;
            STEP_HL: sh = half;
            STEP_LH: sh = half;
            default: sh = 2 * half;
        endcase
        return sh;
    endfunction

    // Which operand halves a step consumes.
    function automatic logic step_uses_a_hi(input logic [1:0] step);
        return step[0];
    endfunction

    function automatic logic step_uses_b_hi(input logic [1:0] step);
        return step[1];
    endfunction

endpackage

// File: rtl/mult8.sv
// Narrow unsigned combinational multiplier shared by the sequencer.
// Default is 8x8; the operand width follows the caller's half width.
module mult8 #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Zero-extend both operands so the product is computed at full width.
    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier. One HALF x HALF array is
// time-shared over four steps; shifted partial products accumulate into a
// 2*WIDTH register. Request side and result side are valid/ready pairs.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. A valid output holds its data stable until accepted, and
// ready never depends combinationally on the matching valid.
import mult_seq_ctrl_pkg::*;

module mult_seq_ctrl #(
    parameter int WIDTH     = 16,            // operand width, must be even
    parameter int HALF      = WIDTH / 2,     // derived, do not override
    parameter bit ZERO_SKIP = 1'b1           // zero operand bypasses MUL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;
    logic [1:0]           step_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    logic                 accept;
    logic                 zero_op;
    logic                 skip;
    logic                 last_step;

    assign accept    = req_valid & req_ready;
    assign zero_op   = (in1 == '0) || (in2 == '0);
    assign skip      = ZERO_SKIP && zero_op;
    assign last_step = (step_q == STEP_HH);

    // ------------------------------------------------------------------
    // Partial-product datapath
    // ------------------------------------------------------------------
    logic [HALF-1:0]      a_sel;
    logic [HALF-1:0]      b_sel;
    logic [2*HALF-1:0]    pp;
    logic [2*WIDTH-1:0]   pp_ext;
    logic [2*WIDTH-1:0]   pp_shifted;
    logic [2*WIDTH-1:0]   acc_sum;

    // Operand half selection for the current step; only latched operands
    // reach the array, so in1/in2 are free to change after accept.
    always_comb begin
        a_sel = a_r[HALF-1:0];
        b_sel = b_r[HALF-1:0];
        if (step_uses_a_hi(step_q)) begin
            a_sel = a_r[WIDTH-1:HALF];
        end
        if (step_uses_b_hi(step_q)) begin
            b_sel = b_r[WIDTH-1:HALF];
        end
    end

    mult8 #(
        .W (HALF)
    ) u_mult8 (
        .a (a_sel),
        .b (b_sel),
        .p (pp)
    );

    // Widen, position and add the partial product. The sum of all four
    // shifted products is the exact product, so truncation never bites.
    always_comb begin
        pp_ext     = {{(2*WIDTH-2*HALF){1'b0}}, pp};
        pp_shifted = pp_ext << step_shift(step_q, HALF);
        acc_sum    = acc_q + pp_shifted;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; asynchronous reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; unused encoding behaves as IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_MUL: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = skip ? ST_DONE : ST_MUL;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Operand latch, step counter, accumulator and registered result.
    // The result only changes on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            acc_q  <= '0;
            step_q <= STEP_LL;
            out    <= '0;
        end else if (accept) begin
            a_r    <= in1;
            b_r    <= in2;
            acc_q  <= '0;
            step_q <= STEP_LL;
            if (skip) begin
                out <= '0;
            end
        end else if (state_q == ST_MUL) begin
            acc_q  <= acc_sum;
            step_q <= step_q + 2'd1;
            if (last_step) begin
                out <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: driver issues operand requests and records the
// expected product, latency and busy length; an independent monitor pops
// and checks whenever a result is presented.
module tb_mult_seq_ctrl;

  localparam int W = 16;

  // clock / reset / DUT signals
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out;
  logic           busy;

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_cyc_q[$];
  int             busy_q[$];
  int             total = 0;
  int             bad = 0;

  // control knobs and monitor state
  int             cyc = 0;
  bit             mon_en = 1'b0;
  bit             scramble_en = 1'b0;
  bit             rand_ready = 1'b0;
  int             bp_next = 0;
  bit             m_seen = 1'b0;
  bit             m_hs = 1'b0;
  logic [2*W-1:0] m_held = '0;
  int             m_bcnt = 0;
  int             m_bp = 0;

  mult_seq_ctrl #(
    .WIDTH     (W),
    .ZERO_SKIP (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic product plus timing rules of the block.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int guard;
    guard = 0;
    @(negedge clk);
    in1 = a;
    in2 = b;
    req_valid = 1'b1;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (track) begin
      exp_q.push_back(32'(a) * 32'(b));
      lat_q.push_back((a == '0 || b == '0) ? 1 : 5);
      acc_cyc_q.push_back(cyc);
      busy_q.push_back((a == '0 || b == '0) ? 0 : 4);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Input scrambler: operands wander while the multiply is in progress.
  always @(posedge clk) begin
    #2;
    if (scramble_en && busy && !req_valid) begin
      in1 = 16'($urandom);
      in2 = 16'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*W-1:0] e;
    int l;
    int ac;
    int bx;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        m_seen = 1'b0;
        m_hs   = 1'b0;
        m_bcnt = 0;
        m_bp   = 0;
      end else begin
        if (m_hs) begin
          m_hs   = 1'b0;
          m_seen = 1'b0;
          check("valid_drop", 64'(out_valid), 64'd0);
          check("idle_ready", 64'(req_ready), 64'd1);
        end
        if (busy) m_bcnt++;
        if (out_valid) begin
          if (!m_seen) begin
            m_seen = 1'b1;
            m_held = out;
            if (exp_q.size() == 0) begin
              check("unexpected_out", 64'd1, 64'd0);
            end else begin
              e  = exp_q.pop_front();
              l  = lat_q.pop_front();
              ac = acc_cyc_q.pop_front();
              bx = busy_q.pop_front();
              check("product", 64'(out), 64'(e));
              check("latency", 64'(cyc - ac + 1), 64'(l));
              check("busy_cycles", 64'(m_bcnt), 64'(bx));
            end
            m_bcnt  = 0;
            m_bp    = bp_next;
            bp_next = 0;
          end else begin
            check("hold_out", 64'(out), 64'(m_held));
          end
          check("ready_in_done", 64'(req_ready), 64'd0);
          check("busy_in_done", 64'(busy), 64'd0);
        end
        if (out_valid) begin
          if (m_bp > 0) begin
            out_ready = 1'b0;
            m_bp--;
          end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        if (out_valid && out_ready) m_hs = 1'b1;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    // reset values, asserted asynchronously
    #2;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // directed products
    send(16'h00FF, 16'h00FF, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h1234, 16'h5678, 1'b1);
    send(16'h0000, 16'hABCD, 1'b1);
    send(16'hABCD, 16'h0000, 1'b1);
    bp_next = 3;
    send(16'h0003, 16'h0005, 1'b1);
    wait_drain();

    // reset during the third multiply step
    mon_en = 1'b0;
    send(16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_out", 64'(out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    send(16'h0002, 16'h0003, 1'b1);
    wait_drain();

    // randomized operands, ready and in-flight operand changes
    rand_ready  = 1'b1;
    scramble_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
      if (i % 6 == 5) bp_next = $urandom_range(1, 4);
      send(a, b, 1'b1);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Multi-cycle sequencer that computes an unsigned WIDTH x WIDTH product by time-sharing one HALF x HALF combinational partial-product multiplier.
- Issues four partial products (lo*lo, hi*lo, lo*hi, hi*hi), shifts each and accumulates into a 2*WIDTH result.
- Sits between the ALU operand/result handshake and the shared 8x8 multiplier, replacing a full-width combinational array with one narrow array plus control.

Parameters:
- WIDTH, 16, operand width; must be even.
- HALF, WIDTH/2, partial-product multiplier operand width (derived; do not override).
- ZERO_SKIP, 1, when 1 a zero operand bypasses the MUL steps.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  operands valid.
- req_ready  output  1  controller can accept operands.
- in1  input  WIDTH  multiplicand, unsigned.
- in2  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out  output  2*WIDTH  product in1*in2.
- busy  output  1  high in MUL state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; clk and rst are the only clock and reset ports.
- Reset values: state=IDLE, step=0, acc=0, out=0, out_valid=0, busy=0, req_ready=1 (IDLE). Operand registers cleared to 0.
- States:
  - IDLE: req_ready=1. On req_valid: latch in1 -> a_r, in2 -> b_r, acc<=0, step<=0, go MUL. With ZERO_SKIP=1 and in1==0 or in2==0: acc<=0, go DONE directly.
  - MUL: busy=1, req_ready=0. Each cycle, feed the sub-multiplier per step:
    - step0: a_lo*b_lo, shift 0.
    - step1: a_hi*b_lo, shift HALF.
    - step2: a_lo*b_hi, shift HALF.
    - step3: a_hi*b_hi, shift WIDTH.
  - MUL update: acc <= acc + (pp << shift), truncated to 2*WIDTH (mathematically never overflows). step increments. After step3, go DONE.
  - DONE: out_valid=1, out=acc, req_ready=0. When out_ready=1, go IDLE (out_valid low next cycle).
- Latency (accept edge = edge where req_valid & req_ready):
  - Normal path: out_valid high after 5 edges (4 MUL cycles + DONE entry).
  - Zero-skip path: out_valid high 1 edge after accept.
- Throughput: one product per 6 cycles. One IDLE bubble between the out handshake and the next accept; no same-cycle accept in DONE.
- Backpressure: out and out_valid held stable while out_ready=0 in DONE. out_ready is ignored outside DONE.
- Operand isolation: in1/in2 may change freely after accept; only a_r/b_r feed the datapath.
- req_valid deasserted in IDLE: no state change.
- Reset mid-operation (MUL or DONE): immediate return to IDLE. Result discarded, out_valid=0, no output.
- out is registered and updates only on entry to DONE. It holds its last value in IDLE and MUL; consumers qualify with out_valid.
- Sub-multiplier is purely combinational; its path into the accumulator adder must close in one cycle.

Decomposition:
- Shared ALU package:
  - state encoding constants: ST_IDLE=2'd0, ST_MUL=2'd1, ST_DONE=2'd2 (2'd3 unused, decodes to IDLE).
  - step shift table constants: 0, HALF, HALF, WIDTH.
- One sub-module: the team's existing 8x8 combinational multiplier, mult8 (HALF=8), instantiated once. Operand muxes and the accumulator adder stay in mult_seq_ctrl.

Test Plan:
- in1=0x00FF, in2=0x00FF, out_ready=1 -> out_valid after 5 edges, out=0x0000FE01, busy high exactly 4 cycles.
- in1=0xFFFF, in2=0xFFFF -> out=0xFFFE0001; in1=0x1234, in2=0x5678 -> out=0x06260060.
- in1=0x0000, in2=0xABCD, ZERO_SKIP=1 -> out_valid 1 edge after accept, out=0, busy never high.
- in1=0x0003, in2=0x0005, out_ready held 0 for 3 cycles in DONE -> out=0x0000000F stable with out_valid high; req_ready=0 throughout; IDLE one edge after out_ready=1.
- Accept 0x1234*0x5678, assert rst during step 2 -> all outputs return to reset values asynchronously. A fresh request 0x0002*0x0003 after release -> out=0x00000006.
- Change in1/in2 every cycle during MUL -> result equals the operands latched at accept.
